// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one-entry skid buffer
//
// Purpose:
//   Owns the 3-bit program counter, requests instructions from instruction
//   memory and drives the instruction/PC pair captured every cycle by the
//   IF/ID register. Outputs hold on stall; a NOP bubble (valid_out=0) is
//   presented whenever no valid instruction is available.
//
// Optional feature macro: HALT_DETECT_EN
//   Defined   : an instruction whose opcode equals HALT_OPCODE is presented
//               once, then fetch stops (halted=1) until redirect or reset.
//   Undefined : no HALT state; the halt opcode is an ordinary instruction
//               and o_halted is tied low.
//
// Ports:
//   i_clk              clock, rising edge
//   i_reset            asynchronous reset, active low
//   i_stall            hazard hold; IF/ID-facing outputs keep their value
//   i_redirect         taken branch/jump; flush and reload PC
//   i_redirect_pc[2:0] redirect target
//   o_imem_req         fetch request (level)
//   o_imem_addr[2:0]   fetch address, always the internal PC
//   i_imem_ack         i_imem_rdata valid for o_imem_addr this cycle
//   i_imem_rdata[15:0] fetched instruction
//   o_instruction_out  instruction to IF/ID
//   o_pc_out[2:0]      PC of o_instruction_out
//   o_valid_out        o_instruction_out is real (0 = bubble)
//   o_halted           fetch halted

module fetch_unit #(
   parameter logic [2:0]  RESET_PC    = 3'd0,
   parameter logic [15:0] NOP_INSTR   = 16'h0000,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [2:0]  i_redirect_pc,
   output logic        o_imem_req,
   output logic [2:0]  o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [15:0] i_imem_rdata,
   output logic [15:0] o_instruction_out,
   output logic [2:0]  o_pc_out,
   output logic        o_valid_out,
   output logic        o_halted
);

`ifdef HALT_DETECT_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_FULL  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;
   // State entered after a halt instruction has been presented.
   localparam state_t ST_ON_HALT = ST_HALT;
   localparam logic   HALT_EN    = 1'b1;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_FULL  = 2'd2
   } state_t;
   // Without halt detection a halt opcode simply keeps fetching.
   localparam state_t ST_ON_HALT = ST_FETCH;
   localparam logic   HALT_EN    = 1'b0;
`endif

   state_t      r_state;
   logic [2:0]  r_pc;
   logic [15:0] r_instr;
   logic [2:0]  r_pc_out;
   logic        r_valid;
   logic [15:0] r_buf_instr;
   logic [2:0]  r_buf_pc;

   state_t      w_state_n;
   logic [2:0]  w_pc_n;
   logic [15:0] w_instr_n;
   logic [2:0]  w_pc_out_n;
   logic        w_valid_n;
   logic [15:0] w_buf_instr_n;
   logic [2:0]  w_buf_pc_n;

   // Halt recognition collapses to constant 0 when the feature is not built.
   function automatic logic f_is_halt(input logic [15:0] ins);
      return HALT_EN && (ins[15:12] == HALT_OPCODE);
   endfunction

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= ST_IDLE;
         r_pc        <= RESET_PC;
         r_instr     <= NOP_INSTR;
         r_pc_out    <= 3'd0;
         r_valid     <= 1'b0;
         r_buf_instr <= NOP_INSTR;
         r_buf_pc    <= 3'd0;
      end else begin
         r_state     <= w_state_n;
         r_pc        <= w_pc_n;
         r_instr     <= w_instr_n;
         r_pc_out    <= w_pc_out_n;
         r_valid     <= w_valid_n;
         r_buf_instr <= w_buf_instr_n;
         r_buf_pc    <= w_buf_pc_n;
      end
   end

   always_comb begin
      w_state_n     = r_state;
      w_pc_n        = r_pc;
      w_instr_n     = r_instr;
      w_pc_out_n    = r_pc_out;
      w_valid_n     = r_valid;
      w_buf_instr_n = r_buf_instr;
      w_buf_pc_n    = r_buf_pc;

      if (i_redirect) begin
         // Redirect wins over stall and discards any same-cycle ack.
         w_state_n     = ST_FETCH;
         w_pc_n        = i_redirect_pc;
         w_instr_n     = NOP_INSTR;
         w_valid_n     = 1'b0;
         w_buf_instr_n = NOP_INSTR;
         w_buf_pc_n    = 3'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_n = ST_FETCH;
            end
            ST_FETCH: begin
               if (i_imem_ack) begin
                  w_pc_n = r_pc + 3'd1;
                  if (i_stall) begin
                     // IF/ID cannot take it: park it and stop requesting.
                     w_buf_instr_n = i_imem_rdata;
                     w_buf_pc_n    = r_pc;
                     w_state_n     = ST_FULL;
                  end else begin
                     w_instr_n  = i_imem_rdata;
                     w_pc_out_n = r_pc;
                     w_valid_n  = 1'b1;
                     w_state_n  = f_is_halt(i_imem_rdata) ? ST_ON_HALT : ST_FETCH;
                  end
               end else if (!i_stall) begin
                  w_instr_n = NOP_INSTR;
                  w_valid_n = 1'b0;
               end
            end
            ST_FULL: begin
               if (!i_stall) begin
                  w_instr_n     = r_buf_instr;
                  w_pc_out_n    = r_buf_pc;
                  w_valid_n     = 1'b1;
                  w_buf_instr_n = NOP_INSTR;
                  w_buf_pc_n    = 3'd0;
                  w_state_n     = f_is_halt(r_buf_instr) ? ST_ON_HALT : ST_FETCH;
               end
            end
`ifdef HALT_DETECT_EN
            ST_HALT: begin
               // Stall is ignored here; keep feeding bubbles.
               w_instr_n = NOP_INSTR;
               w_valid_n = 1'b0;
            end
`endif
            default: begin
               w_state_n = ST_IDLE;
            end
         endcase
      end
   end

   // Request and address come straight from registers, so they only move
   // on clock edges and stay stable while waiting for an ack.
   assign o_imem_req        = (r_state == ST_FETCH);
   assign o_imem_addr       = r_pc;
   assign o_instruction_out = r_instr;
   assign o_pc_out          = r_pc_out;
   assign o_valid_out       = r_valid;
`ifdef HALT_DETECT_EN
   assign o_halted          = (r_state == ST_HALT);
`else
   assign o_halted          = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit

module tb_fetch_unit;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_stall;
   logic        i_redirect;
   logic [2:0]  i_redirect_pc;
   logic        o_imem_req;
   logic [2:0]  o_imem_addr;
   logic        i_imem_ack;
   logic [15:0] i_imem_rdata;
   logic [15:0] o_instruction_out;
   logic [2:0]  o_pc_out;
   logic        o_valid_out;
   logic        o_halted;

   fetch_unit dut (
      .i_clk             (i_clk),
      .i_reset           (i_reset),
      .i_stall           (i_stall),
      .i_redirect        (i_redirect),
      .i_redirect_pc     (i_redirect_pc),
      .o_imem_req        (o_imem_req),
      .o_imem_addr       (o_imem_addr),
      .i_imem_ack        (i_imem_ack),
      .i_imem_rdata      (i_imem_rdata),
      .o_instruction_out (o_instruction_out),
      .o_pc_out          (o_pc_out),
      .o_valid_out       (o_valid_out),
      .o_halted          (o_halted)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [15:0] ins;
      logic [2:0]  pc;
   } sb_t;

   typedef struct {
      logic       st;
      logic       rd;
      logic [2:0] rpc;
      logic       ak;
      logic       e_req;
      logic [2:0] e_addr;
      logic       e_valid;
   } vec_t;

   logic [15:0] mem [8];
   sb_t         q [$];
   vec_t        tbl [$];
   logic [2:0]  exp_pc;
   logic [15:0] last_ins;
   logic [2:0]  last_pc;
   logic        last_valid;
   int          n_cmp = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic rd, input logic [2:0] rpc,
                               input logic ak, input logic e_req, input logic [2:0] e_addr,
                               input logic e_valid);
      vec_t v;
      v.st = st; v.rd = rd; v.rpc = rpc; v.ak = ak;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      return v;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_instr"},  o_instruction_out, 16'h0000);
      chk({tag, "_pc_out"}, 16'(o_pc_out), 16'd0);
      chk({tag, "_valid"},  16'(o_valid_out), 16'd0);
      chk({tag, "_req"},    16'(o_imem_req), 16'd0);
      chk({tag, "_addr"},   16'(o_imem_addr), 16'd0);
      chk({tag, "_halted"}, 16'(o_halted), 16'd0);
   endtask

   task automatic sb_reset();
      q.delete();
      exp_pc     = 3'd0;
      last_ins   = 16'h0000;
      last_pc    = 3'd0;
      last_valid = 1'b0;
   endtask

   // Called at a falling edge: drives one cycle of stimulus, memory answers
   // combinationally, then checks outputs at the next falling edge.
   task automatic drive_cycle(input logic st, input logic rd, input logic [2:0] rpc, input logic ak);
      logic ak_eff;
      sb_t  e;
      ak_eff        = ak & o_imem_req;
      i_stall       = st;
      i_redirect    = rd;
      i_redirect_pc = rpc;
      i_imem_ack    = ak_eff;
      i_imem_rdata  = ak_eff ? mem[o_imem_addr] : 16'hDEAD;
      if (rd) begin
         q.delete();
         exp_pc = rpc;
      end else if (ak_eff) begin
         chk("fetch_addr", 16'(o_imem_addr), 16'(exp_pc));
         e.ins = mem[exp_pc];
         e.pc  = exp_pc;
         q.push_back(e);
         exp_pc = exp_pc + 3'd1;
      end
      @(posedge i_clk);
      @(negedge i_clk);
      i_imem_ack = 1'b0;
      i_stall    = 1'b0;
      i_redirect = 1'b0;
      if (rd) begin
         chk("redir_valid", 16'(o_valid_out), 16'd0);
         chk("redir_instr", o_instruction_out, 16'h0000);
      end else if (st) begin
         chk("stall_instr", o_instruction_out, last_ins);
         chk("stall_pc",    16'(o_pc_out), 16'(last_pc));
         chk("stall_valid", 16'(o_valid_out), 16'(last_valid));
      end else if (q.size() != 0) begin
         e = q.pop_front();
         chk("sb_valid", 16'(o_valid_out), 16'd1);
         chk("sb_instr", o_instruction_out, e.ins);
         chk("sb_pc",    16'(o_pc_out), 16'(e.pc));
      end else begin
         chk("bubble_valid", 16'(o_valid_out), 16'd0);
         chk("bubble_instr", o_instruction_out, 16'h0000);
      end
      last_ins   = o_instruction_out;
      last_pc    = o_pc_out;
      last_valid = o_valid_out;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_reset       = 1'b1;
      i_stall       = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = 3'd0;
      i_imem_ack    = 1'b0;
      i_imem_rdata  = 16'h0000;
      for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);

      // stall, redirect, rpc, ack | req, addr, valid (after the edge)
      // ack every cycle, including the 7 -> 0 wrap
      tbl.push_back(mk(0, 0, 3'd0, 0, 1, 3'd0, 0));
      tbl.push_back(mk(0, 0, 3'd0, 1, 1, 3'd1, 1));
      tbl.push_back(mk(0, 0, 3'd0, 1, 1, 3'd2, 1));
      tbl.push_back(mk(0, 0, 3'd0, 1, 1, 3'd3, 1));
      tbl.push_back(mk(0, 0, 3'd0, 1, 1, 3'd4, 1));
      tbl.push_back(mk(0, 0, 3'd0, 1, 1, 3'd5, 1));
      tbl.push_back(mk(0, 0, 3'd0, 1, 1, 3'd6, 1));
      tbl.push_back(mk(0, 0, 3'd0, 1, 1, 3'd7, 1));
      tbl.push_back(mk(0, 0, 3'd0, 1, 1, 3'd0, 1));
      tbl.push_back(mk(0, 0, 3'd0, 1, 1, 3'd1, 1));
      // ack on the third cycle of each request
      tbl.push_back(mk(0, 0, 3'd0, 0, 1, 3'd1, 0));
      tbl.push_back(mk(0, 0, 3'd0, 0, 1, 3'd1, 0));
      tbl.push_back(mk(0, 0, 3'd0, 1, 1, 3'd2, 1));
      tbl.push_back(mk(0, 0, 3'd0, 0, 1, 3'd2, 0));
      tbl.push_back(mk(0, 0, 3'd0, 0, 1, 3'd2, 0));
      tbl.push_back(mk(0, 0, 3'd0, 1, 1, 3'd3, 1));
      // 4-cycle stall with an ack in the first stalled cycle
      tbl.push_back(mk(1, 0, 3'd0, 1, 0, 3'd4, 1));
      tbl.push_back(mk(1, 0, 3'd0, 0, 0, 3'd4, 1));
      tbl.push_back(mk(1, 0, 3'd0, 0, 0, 3'd4, 1));
      tbl.push_back(mk(1, 0, 3'd0, 0, 0, 3'd4, 1));
      tbl.push_back(mk(0, 0, 3'd0, 0, 1, 3'd4, 1));
      tbl.push_back(mk(0, 0, 3'd0, 1, 1, 3'd5, 1));
      tbl.push_back(mk(0, 0, 3'd0, 1, 1, 3'd6, 1));
      // redirect with simultaneous ack and stall
      tbl.push_back(mk(1, 1, 3'd5, 1, 1, 3'd5, 0));
      tbl.push_back(mk(0, 0, 3'd0, 1, 1, 3'd6, 1));
      // redirect out of FULL drops the buffered entry
      tbl.push_back(mk(1, 0, 3'd0, 1, 0, 3'd7, 1));
      tbl.push_back(mk(0, 1, 3'd2, 0, 1, 3'd2, 0));
      tbl.push_back(mk(0, 0, 3'd0, 1, 1, 3'd3, 1));

      // Power-on reset, asserted between edges.
      #2 i_reset = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk_reset_vals("por");
      sb_reset();
      i_reset = 1'b1;

      for (int k = 0; k < tbl.size(); k++) begin
         drive_cycle(tbl[k].st, tbl[k].rd, tbl[k].rpc, tbl[k].ak);
         chk($sformatf("v%0d_req", k),   16'(o_imem_req),  16'(tbl[k].e_req));
         chk($sformatf("v%0d_addr", k),  16'(o_imem_addr), 16'(tbl[k].e_addr));
         chk($sformatf("v%0d_valid", k), 16'(o_valid_out), 16'(tbl[k].e_valid));
      end

      // Halt opcode at pc 2.
      mem[2] = 16'hF123;
      drive_cycle(0, 1, 3'd2, 0);
      chk("halt_redir_addr", 16'(o_imem_addr), 16'd2);
      drive_cycle(0, 0, 3'd0, 1);
`ifdef HALT_DETECT_EN
      chk("halt_req_off", 16'(o_imem_req), 16'd0);
      drive_cycle(0, 0, 3'd0, 1);
      chk("halted_set", 16'(o_halted), 16'd1);
      chk("halted_req", 16'(o_imem_req), 16'd0);
      drive_cycle(1, 0, 3'd0, 0);
      chk("halted_stall", 16'(o_halted), 16'd1);
      drive_cycle(0, 1, 3'd0, 0);
      chk("unhalt_flag", 16'(o_halted), 16'd0);
      chk("unhalt_req",  16'(o_imem_req), 16'd1);
      chk("unhalt_addr", 16'(o_imem_addr), 16'd0);
      drive_cycle(0, 0, 3'd0, 1);
`else
      chk("nohalt_flag", 16'(o_halted), 16'd0);
      chk("nohalt_req",  16'(o_imem_req), 16'd1);
      drive_cycle(0, 0, 3'd0, 1);
      chk("nohalt_flag2", 16'(o_halted), 16'd0);
`endif
      mem[2] = 16'h1002;

      // Reset while holding a buffered instruction; ack during reset ignored.
      drive_cycle(1, 0, 3'd0, 1);
      chk("pre_reset_req", 16'(o_imem_req), 16'd0);
      #2 i_reset = 1'b0;
      #1 chk_reset_vals("async");
      i_imem_ack   = 1'b1;
      i_imem_rdata = 16'hBEEF;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk_reset_vals("held");
      i_imem_ack = 1'b0;
      sb_reset();
      i_reset = 1'b1;
      drive_cycle(0, 0, 3'd0, 0);
      chk("rst2_req",  16'(o_imem_req), 16'd1);
      chk("rst2_addr", 16'(o_imem_addr), 16'd0);
      drive_cycle(0, 0, 3'd0, 1);
      chk("rst2_next", 16'(o_imem_addr), 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
